sb_tx_packet_framing: RTL and testbench

- Sideband TX stage directly downstream of the SB header encoder and SB data encoder.
- Captures a 64-bit header plus an optional 64-bit data payload as one packet into a small packet FIFO.
- Serializes each packet LSB-first onto the 1-bit sideband TX lane with a gated-clock enable, then enforces a minimum idle gap between packets.

---
 rtl/sb_tx_packet_framing.sv | 255 +++++++++++++++++++++++++
 tb/tb_sb_tx_packet_framing.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/sb_tx_packet_framing.sv
//------------------------------------------------------------------------------
// +--------------------------------------------------------------------------+
// | Module      : sb_tx_packet_framing                                       |
// | Description : Sideband TX packet framer. Buffers {has_data, header,      |
// |               data} packets in a small FIFO and serializes each one      |
// |               LSB-first onto the 1-bit sideband lane, header first,      |
// |               then the optional 64-bit payload, followed by a fixed      |
// |               idle gap of GAP_LEN lane cycles.                           |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
//
// Optional feature macro: SB_TX_HDR_PARITY_EN
//   When defined, header[62] is replaced by the even parity of header[61:0]
//   and header[63] by the parity of the payload (0 for header-only packets)
//   at the moment the packet is loaded into the serializer.
//
// Parameters:
//   FIFO_DEPTH  packet slots, power of 2, >= 2
//   GAP_LEN     idle lane cycles after each packet, >= 1
//
// Ports:
//   i_clk        sideband TX clock
//   i_rst_n      asynchronous active-low reset
//   i_hdr_valid  push strobe (header, and data if i_d_valid, captured)
//   i_header     64-bit packet header
//   i_d_valid    packet carries i_data
//   i_data       64-bit payload
//   o_ready      FIFO not full
//   o_txdata_sb  serial lane bit
//   o_tx_clk_en  high on every cycle carrying a valid lane bit
//   o_busy       serializer active (header, data or gap)
//   o_pkt_done   one-cycle pulse on the first lane cycle after a packet
//   o_overflow   sticky: a push arrived while the FIFO was full
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module sb_tx_packet_framing #(
    parameter int FIFO_DEPTH = 4,
    parameter int GAP_LEN    = 32
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_hdr_valid,
    input  logic [63:0] i_header,
    input  logic        i_d_valid,
    input  logic [63:0] i_data,
    output logic        o_ready,
    output logic        o_txdata_sb,
    output logic        o_tx_clk_en,
    output logic        o_busy,
    output logic        o_pkt_done,
    output logic        o_overflow
);

    localparam int c_ADDR_W = $clog2(FIFO_DEPTH);
    localparam int c_PTR_W  = c_ADDR_W + 1;
    localparam int c_GAP_W  = $clog2(GAP_LEN + 1);

    localparam logic [c_PTR_W-1:0] c_DEPTH    = c_PTR_W'(FIFO_DEPTH);
    localparam logic [c_GAP_W-1:0] c_GAP_LOAD = c_GAP_W'(GAP_LEN - 1);

    localparam logic [1:0] c_ST_IDLE = 2'd0;
    localparam logic [1:0] c_ST_HDR  = 2'd1;
    localparam logic [1:0] c_ST_DATA = 2'd2;
    localparam logic [1:0] c_ST_GAP  = 2'd3;

    // ------------------------------------------------------------------
    // Packet FIFO
    // ------------------------------------------------------------------
    logic [63:0]        r_fifo_hdr  [FIFO_DEPTH];
    logic [63:0]        r_fifo_data [FIFO_DEPTH];
    logic               r_fifo_hd   [FIFO_DEPTH];

    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic               r_ready;
    logic               r_overflow;

    logic               w_push;
    logic               w_pop;
    logic               w_empty;
    logic [c_PTR_W-1:0] w_wr_ptr_nxt;
    logic [c_PTR_W-1:0] w_rd_ptr_nxt;
    logic [c_PTR_W-1:0] w_count_nxt;

    logic [63:0]        w_head_hdr;
    logic [63:0]        w_head_data;
    logic               w_head_hd;
    logic [63:0]        w_load_hdr;

    // r_ready always reflects the current occupancy, so a push is accepted
    // exactly when the FIFO is not full; a pop in the same cycle does not
    // rescue a push into a full FIFO.
    assign w_push  = i_hdr_valid & r_ready;
    assign w_empty = (r_wr_ptr == r_rd_ptr);

    assign w_wr_ptr_nxt = r_wr_ptr + {{(c_PTR_W-1){1'b0}}, w_push};
    assign w_rd_ptr_nxt = r_rd_ptr + {{(c_PTR_W-1){1'b0}}, w_pop};
    assign w_count_nxt  = w_wr_ptr_nxt - w_rd_ptr_nxt;

    assign w_head_hdr  = r_fifo_hdr [r_rd_ptr[c_ADDR_W-1:0]];
    assign w_head_data = r_fifo_data[r_rd_ptr[c_ADDR_W-1:0]];
    assign w_head_hd   = r_fifo_hd  [r_rd_ptr[c_ADDR_W-1:0]];

    // Payload storage needs no reset: an entry is only read after it has
    // been written, and the pointers are reset.
    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_fifo_hdr [r_wr_ptr[c_ADDR_W-1:0]] <= i_header;
            r_fifo_data[r_wr_ptr[c_ADDR_W-1:0]] <= i_d_valid ? i_data : 64'd0;
            r_fifo_hd  [r_wr_ptr[c_ADDR_W-1:0]] <= i_d_valid;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_ready    <= 1'b1;
            r_overflow <= 1'b0;
        end else begin
            r_wr_ptr   <= w_wr_ptr_nxt;
            r_rd_ptr   <= w_rd_ptr_nxt;
            r_ready    <= (w_count_nxt != c_DEPTH);
            r_overflow <= r_overflow | (i_hdr_valid & ~r_ready);
        end
    end

    // ------------------------------------------------------------------
    // Header adjustment applied as the head entry is loaded
    // ------------------------------------------------------------------
    always_comb begin
        w_load_hdr = w_head_hdr;
`ifdef SB_TX_HDR_PARITY_EN
        w_load_hdr[62] = ^w_head_hdr[61:0];
        w_load_hdr[63] = w_head_hd & (^w_head_data);
`else
        w_load_hdr[63:62] = w_head_hdr[63:62];
`endif
    end

    // ------------------------------------------------------------------
    // Serializer FSM
    // ------------------------------------------------------------------
    logic [1:0]         r_state;
    logic [5:0]         r_bit_cnt;
    logic [c_GAP_W-1:0] r_gap_cnt;
    logic [63:0]        r_cur_hdr;
    logic [63:0]        r_cur_data;
    logic               r_cur_hd;

    logic               w_gap_last;

    assign w_gap_last = (r_state == c_ST_GAP) && (r_gap_cnt == '0);

    // Pop from IDLE, or on the last gap cycle so that back-to-back packets
    // are separated by exactly GAP_LEN idle lane cycles.
    assign w_pop = ~w_empty & ((r_state == c_ST_IDLE) | w_gap_last);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state    <= c_ST_IDLE;
            r_bit_cnt  <= '0;
            r_gap_cnt  <= '0;
            r_cur_hdr  <= '0;
            r_cur_data <= '0;
            r_cur_hd   <= 1'b0;
        end else begin
            if (w_pop) begin
                r_cur_hdr  <= w_load_hdr;
                r_cur_data <= w_head_data;
                r_cur_hd   <= w_head_hd;
            end

            case (r_state)
                c_ST_IDLE: begin
                    if (!w_empty) begin
                        r_state   <= c_ST_HDR;
                        r_bit_cnt <= '0;
                    end
                end
                c_ST_HDR: begin
                    r_bit_cnt <= r_bit_cnt + 6'd1;
                    if (r_bit_cnt == 6'd63) begin
                        if (r_cur_hd) begin
                            r_state <= c_ST_DATA;
                        end else begin
                            r_state   <= c_ST_GAP;
                            r_gap_cnt <= c_GAP_LOAD;
                        end
                    end
                end
                c_ST_DATA: begin
                    r_bit_cnt <= r_bit_cnt + 6'd1;
                    if (r_bit_cnt == 6'd63) begin
                        r_state   <= c_ST_GAP;
                        r_gap_cnt <= c_GAP_LOAD;
                    end
                end
                c_ST_GAP: begin
                    if (r_gap_cnt == '0) begin
                        r_bit_cnt <= '0;
                        r_state   <= w_empty ? c_ST_IDLE : c_ST_HDR;
                    end else begin
                        r_gap_cnt <= r_gap_cnt - {{(c_GAP_W-1){1'b0}}, 1'b1};
                    end
                end
                default: begin
                    r_state <= c_ST_IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Registered lane outputs
    // ------------------------------------------------------------------
    // All lane-side outputs are registered from the current state so they
    // stay mutually aligned: bit 0 appears the cycle after the state enters
    // HDR, o_pkt_done marks the first idle lane cycle, and o_busy covers
    // exactly the bit and gap cycles seen on the lane.
    logic r_txdata;
    logic r_tx_clk_en;
    logic r_busy;
    logic r_pkt_done;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_txdata    <= 1'b0;
            r_tx_clk_en <= 1'b0;
            r_busy      <= 1'b0;
            r_pkt_done  <= 1'b0;
        end else begin
            r_tx_clk_en <= (r_state == c_ST_HDR) || (r_state == c_ST_DATA);
            r_busy      <= (r_state != c_ST_IDLE);
            r_pkt_done  <= (r_state == c_ST_GAP) && (r_gap_cnt == c_GAP_LOAD);
            case (r_state)
                c_ST_HDR:  r_txdata <= r_cur_hdr[r_bit_cnt];
                c_ST_DATA: r_txdata <= r_cur_data[r_bit_cnt];
                default:   r_txdata <= 1'b0;
            endcase
        end
    end

    assign o_ready     = r_ready;
    assign o_overflow  = r_overflow;
    assign o_txdata_sb = r_txdata;
    assign o_tx_clk_en = r_tx_clk_en;
    assign o_busy      = r_busy;
    assign o_pkt_done  = r_pkt_done;

endmodule

`default_nettype wire

// File: tb/tb_sb_tx_packet_framing.sv
//------------------------------------------------------------------------------
// +--------------------------------------------------------------------------+
// | Module      : tb_sb_tx_packet_framing                                    |
// | Description : Directed self-checking bench for sb_tx_packet_framing      |
// |               (FIFO_DEPTH = 4, GAP_LEN = 32).                            |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module tb_sb_tx_packet_framing;

`ifdef SB_TX_HDR_PARITY_EN
    localparam bit c_PAR_EN = 1'b1;
`else
    localparam bit c_PAR_EN = 1'b0;
`endif

    logic        clk;
    logic        rst_n;
    logic        hdr_valid;
    logic [63:0] header;
    logic        d_valid;
    logic [63:0] data;
    logic        ready;
    logic        txdata_sb;
    logic        tx_clk_en;
    logic        busy;
    logic        pkt_done;
    logic        overflow;

    int checks = 0;
    int errors = 0;

    sb_tx_packet_framing #(
        .FIFO_DEPTH (4),
        .GAP_LEN    (32)
    ) dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_hdr_valid (hdr_valid),
        .i_header    (header),
        .i_d_valid   (d_valid),
        .i_data      (data),
        .o_ready     (ready),
        .o_txdata_sb (txdata_sb),
        .o_tx_clk_en (tx_clk_en),
        .o_busy      (busy),
        .o_pkt_done  (pkt_done),
        .o_overflow  (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    // Expected on-lane header for a pushed packet.
    function automatic logic [63:0] exp_hdr(input logic [63:0] h, input logic hd,
                                            input logic [63:0] d);
        logic [63:0] r;
        r = h;
        if (c_PAR_EN) begin
            r[62] = ^h[61:0];
            r[63] = hd & (^d);
        end
        return r;
    endfunction

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock and sample 1 ns after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [63:0] h, input logic hd, input logic [63:0] d);
        header    = h;
        d_valid   = hd;
        data      = d;
        hdr_valid = 1'b1;
        step();
        hdr_valid = 1'b0;
    endtask

    task automatic wait_en(input int budget);
        int n;
        n = 0;
        while (!tx_clk_en && n < budget) begin
            step();
            n++;
        end
        chk("wait_clk_en", 128'(tx_clk_en), 128'd1);
    endtask

    // Collect the contiguous run of clk_en cycles starting at the current sample.
    task automatic grab(output int len, output logic [127:0] bits);
        len  = 0;
        bits = '0;
        while (tx_clk_en && len < 200) begin
            if (len < 128) bits[len] = txdata_sb;
            len++;
            step();
        end
    endtask

    task automatic count_idle(input int budget, output int n);
        n = 0;
        while (!tx_clk_en && n < budget) begin
            n++;
            step();
        end
    endtask

    initial begin
        int           len;
        int           n;
        logic [127:0] bits;
        logic [63:0]  h0;

        rst_n     = 1'b0;
        hdr_valid = 1'b0;
        header    = '0;
        d_valid   = 1'b0;
        data      = '0;
        step();
        step();

        // Reset state
        chk("rst_ready",    128'(ready),     128'd1);
        chk("rst_clk_en",   128'(tx_clk_en), 128'd0);
        chk("rst_txdata",   128'(txdata_sb), 128'd0);
        chk("rst_busy",     128'(busy),      128'd0);
        chk("rst_pkt_done", 128'(pkt_done),  128'd0);
        chk("rst_overflow", 128'(overflow),  128'd0);
        rst_n = 1'b1;
        step();

        // 1: header-only packet, latency and framing
        push(64'hA5A5_0000_0000_0001, 1'b0, 64'd0);      // E0
        step();                                          // after E1
        chk("t1_e1_clk_en", 128'(tx_clk_en), 128'd0);
        step();                                          // after E2
        chk("t1_e2_clk_en", 128'(tx_clk_en), 128'd1);
        chk("t1_e2_bit0",   128'(txdata_sb), 128'd1);
        chk("t1_e2_busy",   128'(busy),      128'd1);
        grab(len, bits);                                 // returns after E66
        chk("t1_len",       128'(len), 128'd64);
        chk("t1_bits",      128'(bits[63:0]),
            128'(exp_hdr(64'hA5A5_0000_0000_0001, 1'b0, 64'd0)));
        chk("t1_pkt_done",  128'(pkt_done),  128'd1);
        chk("t1_gap_txd",   128'(txdata_sb), 128'd0);
        step();
        chk("t1_pkt_done_1cyc", 128'(pkt_done), 128'd0);
        repeat (30) step();                              // after E97: 32nd idle cycle
        chk("t1_busy_in_gap", 128'(busy), 128'd1);
        step();
        chk("t1_busy_after_gap", 128'(busy), 128'd0);
        chk("t1_clk_en_after_gap", 128'(tx_clk_en), 128'd0);

        // 2: header + data packet
        push(64'h1234_5678_9ABC_DEF0, 1'b1, 64'h0000_0000_0000_FFFF);
        wait_en(10);
        grab(len, bits);
        chk("t2_len",      128'(len), 128'd128);
        chk("t2_hdr",      128'(bits[63:0]),
            128'(exp_hdr(64'h1234_5678_9ABC_DEF0, 1'b1, 64'h0000_0000_0000_FFFF)));
        chk("t2_ones_64_79",   128'(bits[79:64]),  128'h FFFF);
        chk("t2_zeros_80_127", 128'(bits[127:80]), 128'd0);
        chk("t2_pkt_done", 128'(pkt_done), 128'd1);
        count_idle(40, n);
        chk("t2_idle", 128'(n), 128'd40);

        // 3: three back-to-back pushes, order and exact gaps
        push(64'h0000_0000_0000_00C3, 1'b0, 64'hFFFF_0000_FFFF_0000);
        push(64'h8000_0000_0000_0011, 1'b1, 64'hDEAD_BEEF_0123_4567);
        push(64'h0F0F_0F0F_0F0F_0F0F, 1'b0, 64'd0);
        wait_en(10);
        grab(len, bits);
        chk("t3_p1_len",  128'(len), 128'd64);
        chk("t3_p1_bits", 128'(bits[63:0]),
            128'(exp_hdr(64'h0000_0000_0000_00C3, 1'b0, 64'd0)));
        count_idle(60, n);
        chk("t3_gap1", 128'(n), 128'd32);
        grab(len, bits);
        chk("t3_p2_len",  128'(len), 128'd128);
        chk("t3_p2_bits", bits,
            {64'hDEAD_BEEF_0123_4567,
             exp_hdr(64'h8000_0000_0000_0011, 1'b1, 64'hDEAD_BEEF_0123_4567)});
        count_idle(60, n);
        chk("t3_gap2", 128'(n), 128'd32);
        grab(len, bits);
        chk("t3_p3_len",  128'(len), 128'd64);
        chk("t3_p3_bits", 128'(bits[63:0]),
            128'(exp_hdr(64'h0F0F_0F0F_0F0F_0F0F, 1'b0, 64'd0)));
        count_idle(40, n);
        chk("t3_tail_idle", 128'(n), 128'd40);

        // 4: overflow; one packet in flight, five more pushes into depth-4 FIFO
        h0 = 64'h0000_0000_0000_0100;
        push(h0, 1'b0, 64'd0);
        wait_en(10);                                     // bit 0 of h0 on lane
        for (int i = 0; i < 5; i++) begin
            if (i == 3) chk("t4_ready_before_full", 128'(ready), 128'd1);
            if (i == 4) chk("t4_ready_full",        128'(ready), 128'd0);
            push(64'h0000_0000_0000_0101 + 64'(i), 1'b0, 64'd0);
        end
        chk("t4_overflow", 128'(overflow), 128'd1);
        grab(len, bits);                                 // remainder of in-flight packet
        chk("t4_p0_len",  128'(len), 128'd59);
        chk("t4_p0_bits", 128'(bits[58:0]), 128'(exp_hdr(h0, 1'b0, 64'd0) >> 5));
        count_idle(60, n);
        chk("t4_gap0", 128'(n), 128'd32);
        for (int k = 0; k < 4; k++) begin
            grab(len, bits);
            chk("t4_pk_len",  128'(len), 128'd64);
            chk("t4_pk_bits", 128'(bits[63:0]),
                128'(exp_hdr(64'h0000_0000_0000_0101 + 64'(k), 1'b0, 64'd0)));
            count_idle(40, n);
            chk("t4_pk_gap", 128'(n), (k < 3) ? 128'd32 : 128'd40);
        end
        chk("t4_overflow_sticky", 128'(overflow), 128'd1);
        chk("t4_ready_drained",   128'(ready),    128'd1);

        // 5: asynchronous reset at data bit 20, with a second packet queued
        push(64'h0000_0000_0000_0005, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF);
        push(64'h0000_0000_0000_0006, 1'b0, 64'd0);
        wait_en(10);
        repeat (84) step();                              // data bit 20 on lane
        chk("t5_pre_clk_en", 128'(tx_clk_en), 128'd1);
        chk("t5_pre_txd",    128'(txdata_sb), 128'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t5_async_clk_en",   128'(tx_clk_en), 128'd0);
        chk("t5_async_txd",      128'(txdata_sb), 128'd0);
        chk("t5_async_ready",    128'(ready),     128'd1);
        chk("t5_async_busy",     128'(busy),      128'd0);
        chk("t5_async_overflow", 128'(overflow),  128'd0);
        step();
        step();
        rst_n = 1'b1;
        count_idle(200, n);
        chk("t5_no_residual", 128'(n), 128'd200);
        chk("t5_busy_idle",   128'(busy), 128'd0);

        // 6: header control bits 62/63 (parity feature when enabled)
        push(64'h0000_0000_0000_0003, 1'b1, 64'h0000_0000_0000_0001);
        wait_en(10);
        grab(len, bits);
        chk("t6_len",    128'(len), 128'd128);
        chk("t6_low",    128'(bits[61:0]), 128'h3);
        chk("t6_bit62",  128'(bits[62]),   128'd0);
        chk("t6_bit63",  128'(bits[63]),   128'(c_PAR_EN));
        chk("t6_data",   128'(bits[127:64]), 128'h1);
        count_idle(40, n);
        chk("t6_idle", 128'(n), 128'd40);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
